// File: rtl/mem_seq_ctrl_pkg.sv
// Shared types for the MAR/MDR/RAM access sequencer.
// Holds the state encoding, the idle strobe vector and the parameter checks.
package mem_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_LOADW,
    S_WRITE,
    S_READ,
    S_DRIVE,
    S_DONE
  } state_e;

  typedef struct packed {
    logic nLm;
    logic nLw;
    logic nLr;
    logic Ew;
    logic Er;
    logic nWE;
    logic nOE;
  } strb_t;

  localparam strb_t STRB_IDLE = '{
    nLm: 1'b1, nLw: 1'b1, nLr: 1'b1,
    Ew: 1'b0, Er: 1'b0,
    nWE: 1'b1, nOE: 1'b1
  };

  function automatic bit params_ok(
    input int n, input int wr, input int rd
  );
    return (n >= 2) && (n <= 4) &&
           (wr >= 1) && (wr <= 15) &&
           (rd >= 0) && (rd <= 15);
  endfunction

endpackage

// File: rtl/mem_seq_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter.
// Searches from i_ptr upward (mod NREQ) and returns the first requester.
module mem_seq_ctrl_rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_win,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  int w_k;

  // Descending scan so the smallest offset from i_ptr wins last.
  always_comb begin
    o_win = '0;
    o_idx = '0;
    o_any = |i_req;
    w_k   = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_k = int'(i_ptr) + i;
      if (w_k >= NREQ) w_k = w_k - NREQ;
      if (i_req[w_k]) begin
        o_win      = '0;
        o_win[w_k] = 1'b1;
        o_idx      = PW'(w_k);
      end
    end
  end

endmodule

// File: rtl/mem_seq_ctrl.sv
// Memory-access sequencer: arbitrates the MAR/MDR/RAM path and
// steps one read or write through its strobes (Moore outputs).
module mem_seq_ctrl
  import mem_seq_ctrl_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int WR_CYC  = 1,
  parameter int RD_WAIT = 0
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] we,
  output logic [NREQ-1:0] gnt,
  output logic            done,
  output logic            busy,
  output logic            nLm,
  output logic            nLw,
  output logic            nLr,
  output logic            Ew,
  output logic            Er,
  output logic            nWE,
  output logic            nOE
);

  localparam int PW = $clog2(NREQ);

  if (!params_ok(NREQ, WR_CYC, RD_WAIT)) begin : g_bad_param
    $error("mem_seq_ctrl: parameter out of range");
  end

  state_e          r_state;
  state_e          w_next;
  logic [NREQ-1:0] r_gnt;
  logic            r_we;
  logic [PW-1:0]   r_ptr;
  logic [3:0]      r_cnt;

  logic [NREQ-1:0] w_win;
  logic [PW-1:0]   w_idx;
  logic            w_any;
  logic [PW-1:0]   w_ptr_nxt;
  strb_t           w_s;

  mem_seq_ctrl_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_win (w_win),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_ptr_nxt = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_any) w_next = S_ADDR;
      S_ADDR:  w_next = r_we ? S_LOADW : S_READ;
      S_LOADW: w_next = S_WRITE;
      S_WRITE: if (r_cnt == 4'd0) w_next = S_DONE;
      S_READ:  if (r_cnt == 4'd0) w_next = S_DRIVE;
      S_DRIVE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_we    <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_any) begin
        r_gnt <= w_win;
        r_we  <= |(we & w_win);
        r_ptr <= w_ptr_nxt;
      end else if (r_state == S_DONE) begin
        r_gnt <= '0;
      end
      // Counter is preloaded one state ahead so it is valid on entry.
      if (r_state == S_LOADW) begin
        r_cnt <= 4'(WR_CYC - 1);
      end else if (r_state == S_ADDR && !r_we) begin
        r_cnt <= 4'(RD_WAIT);
      end else if ((r_state == S_WRITE || r_state == S_READ) &&
                   r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_comb begin
    w_s = STRB_IDLE;
    unique case (r_state)
      S_ADDR:  w_s.nLm = 1'b0;
      S_LOADW: w_s.nLw = 1'b0;
      S_WRITE: begin
        w_s.Er  = 1'b1;
        w_s.nWE = 1'b0;
      end
      S_READ: begin
        w_s.nOE = 1'b0;
        w_s.nLr = (r_cnt != 4'd0);
      end
      S_DRIVE: w_s.Ew = 1'b1;
      S_DONE:  w_s.Er = r_we;
      default: w_s = STRB_IDLE;
    endcase
  end

  assign gnt  = r_gnt;
  assign done = (r_state == S_DONE);
  assign busy = (r_state != S_IDLE);
  assign nLm  = w_s.nLm;
  assign nLw  = w_s.nLw;
  assign nLr  = w_s.nLr;
  assign Ew   = w_s.Ew;
  assign Er   = w_s.Er;
  assign nWE  = w_s.nWE;
  assign nOE  = w_s.nOE;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Self-checking bench for mem_seq_ctrl: vector table, directed
// corner sequences and a timeline-based random reference model.
module tb_mem_seq_ctrl;

  localparam int NREQ    = 2;
  localparam int WR_CYC  = 1;
  localparam int RD_WAIT = 2;

  // Packed observation: {gnt, done, busy, nLm,nLw,nLr,Ew,Er,nWE,nOE}
  localparam logic [6:0]  S_IDL = 7'b1110011;
  localparam logic [10:0] V_IDLE = {2'b00, 1'b0, 1'b0, S_IDL};

  logic CLK = 1'b0;
  logic CLR = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] we  = '0;
  logic [NREQ-1:0] gnt;
  logic done, busy, nLm, nLw, nLr, Ew, Er, nWE, nOE;
  logic [10:0] obs;

  int checks   = 0;
  int failures = 0;

  mem_seq_ctrl #(
    .NREQ    (NREQ),
    .WR_CYC  (WR_CYC),
    .RD_WAIT (RD_WAIT)
  ) dut (
    .CLK  (CLK),
    .CLR  (CLR),
    .req  (req),
    .we   (we),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .nLm  (nLm),
    .nLw  (nLw),
    .nLr  (nLr),
    .Ew   (Ew),
    .Er   (Er),
    .nWE  (nWE),
    .nOE  (nOE)
  );

  always #5 CLK = ~CLK;

  assign obs = {gnt, done, busy, nLm, nLw, nLr, Ew, Er, nWE, nOE};

  typedef struct {
    logic [1:0]  req;
    logic [1:0]  we;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name,
                     input logic [10:0] act,
                     input logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t",
               name, act, exp, $time);
    end
  endtask

  // Expected outputs from the transaction timeline: offset from the
  // grant edge, the granted one-hot and the direction.
  function automatic logic [10:0] model_vec(input int off,
                                            input logic [1:0] g,
                                            input logic w);
    logic [6:0] s;
    logic d;
    s = S_IDL;
    d = 1'b0;
    if (off < 0) return V_IDLE;
    if (w) begin
      if (off == 0) s[6] = 1'b0;
      else if (off == 1) s[5] = 1'b0;
      else if (off < 2 + WR_CYC) begin
        s[2] = 1'b1;
        s[1] = 1'b0;
      end else begin
        d    = 1'b1;
        s[2] = 1'b1;
      end
    end else begin
      if (off == 0) s[6] = 1'b0;
      else if (off <= 1 + RD_WAIT) begin
        s[0] = 1'b0;
        if (off == 1 + RD_WAIT) s[4] = 1'b0;
      end else if (off == 2 + RD_WAIT) s[3] = 1'b1;
      else d = 1'b1;
    end
    return {g, d, 1'b1, s};
  endfunction

  initial begin
    int m_off;
    int m_len;
    int m_ptr;
    logic [1:0] m_gnt;
    logic m_we;
    logic prev_busy;
    int gap;
    int ngr;
    int n;
    logic [1:0] exp_g;

    // Write (WR_CYC=1) then read (RD_WAIT=2) with req dropped early.
    tbl[0]  = '{2'b01, 2'b01, {2'b01, 1'b0, 1'b1, 7'b0110011}};
    tbl[1]  = '{2'b00, 2'b00, {2'b01, 1'b0, 1'b1, 7'b1010011}};
    tbl[2]  = '{2'b00, 2'b00, {2'b01, 1'b0, 1'b1, 7'b1110101}};
    tbl[3]  = '{2'b00, 2'b00, {2'b01, 1'b1, 1'b1, 7'b1110111}};
    tbl[4]  = '{2'b00, 2'b00, V_IDLE};
    tbl[5]  = '{2'b01, 2'b00, {2'b01, 1'b0, 1'b1, 7'b0110011}};
    tbl[6]  = '{2'b00, 2'b10, {2'b01, 1'b0, 1'b1, 7'b1110010}};
    tbl[7]  = '{2'b00, 2'b00, {2'b01, 1'b0, 1'b1, 7'b1110010}};
    tbl[8]  = '{2'b00, 2'b00, {2'b01, 1'b0, 1'b1, 7'b1100010}};
    tbl[9]  = '{2'b00, 2'b00, {2'b01, 1'b0, 1'b1, 7'b1111011}};
    tbl[10] = '{2'b00, 2'b00, {2'b01, 1'b1, 1'b1, 7'b1110011}};
    tbl[11] = '{2'b00, 2'b00, V_IDLE};

    repeat (2) @(negedge CLK);
    chk("reset_state", obs, V_IDLE);
    CLR = 1'b0;

    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      req = tbl[i].req;
      we  = tbl[i].we;
      @(posedge CLK);
      #1;
      chk($sformatf("vec%0d", i), obs, tbl[i].exp);
    end
    @(negedge CLK);
    chk("no_regrant", obs, V_IDLE);

    // Continuous req=11: grants alternate with one IDLE cycle between.
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    req = 2'b11;
    we  = 2'b00;
    prev_busy = 1'b0;
    gap = 0;
    ngr = 0;
    exp_g = 2'b01;
    for (int c = 0; c < 60 && ngr < 4; c++) begin
      @(posedge CLK);
      #1;
      if (busy && !prev_busy) begin
        chk($sformatf("rr_gnt%0d", ngr), {9'd0, gnt}, {9'd0, exp_g});
        if (ngr > 0) chk($sformatf("rr_gap%0d", ngr), 11'(gap), 11'd1);
        exp_g = ~exp_g;
        ngr++;
      end
      gap = busy ? 0 : gap + 1;
      prev_busy = busy;
    end
    chk("rr_count", 11'(ngr), 11'd4);

    // CLR pulse in the middle of a write.
    @(negedge CLK);
    CLR = 1'b1;
    req = '0;
    @(negedge CLK);
    CLR = 1'b0;
    req = 2'b01;
    we  = 2'b01;
    n = 0;
    while (nWE && n < 10) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("clr_reach_write", {10'd0, nWE}, 11'd0);
    #2;
    CLR = 1'b1;
    #1;
    chk("clr_async_idle", obs, V_IDLE);
    @(negedge CLK);
    CLR = 1'b0;
    req = 2'b10;
    we  = 2'b00;
    @(posedge CLK);
    #1;
    chk("clr_next_gnt", obs, {2'b10, 1'b0, 1'b1, 7'b0110011});

    // Random traffic against the timeline model.
    @(negedge CLK);
    CLR = 1'b1;
    req = '0;
    @(negedge CLK);
    CLR = 1'b0;
    m_off = -1;
    m_len = 0;
    m_ptr = 0;
    m_gnt = '0;
    m_we  = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      req = 2'($urandom_range(0, 3));
      we  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 149) == 0) begin
        CLR = 1'b1;
        #1;
        chk("rand_clr", obs, V_IDLE);
        CLR = 1'b0;
        m_off = -1;
        m_ptr = 0;
      end
      @(posedge CLK);
      if (m_off < 0) begin
        if (req != 0) begin
          int w;
          w = req[m_ptr] ? m_ptr : 1 - m_ptr;
          m_gnt = '0;
          m_gnt[w] = 1'b1;
          m_we  = we[w];
          m_len = m_we ? 3 + WR_CYC : 4 + RD_WAIT;
          m_ptr = (w + 1) % NREQ;
          m_off = 0;
        end
      end else begin
        m_off++;
        if (m_off == m_len) m_off = -1;
      end
      #1;
      chk("rand_out", obs, model_vec(m_off, m_gnt, m_we));
      checks++;
      if ((Ew && !nLw) || (Er && !nOE) || (!nWE && !nOE) ||
          (gnt == 2'b11)) begin
        failures++;
        $display("FAIL invariant: outputs %b violate exclusion at %0t",
                 obs, $time);
      end
      @(negedge CLK);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
